// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and a valid/ready
// handoff to a single consumer. The priority pointer (last_oh_q) rotates so
// that the most recently granted requester always has the lowest priority.
//
// Handshake: grant_valid/grant_oh are offered by the arbiter and held
// stable until the cycle where grant_valid & grant_ready are both high.
// That cycle is the transfer. grant_ready is ignored while grant_valid is low.
module rr_arbiter #(
  parameter int NUM_REQUESTS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQUESTS-1:0] request,
  output logic                    grant_valid,
  input  logic                    grant_ready,
  output logic [NUM_REQUESTS-1:0] grant_oh,
  output logic                    dbg_state_o
);

  localparam int N = NUM_REQUESTS;
  localparam logic [N-1:0]   ONE_N     = N'(1);
  localparam logic [2*N-1:0] ONE_2N    = (2*N)'(1);
  localparam logic [N-1:0]   LAST_INIT = ONE_N << (N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   last_oh_q, last_oh_d;

  logic [N-1:0]   above_last;
  logic [N-1:0]   masked_req;
  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_iso;
  logic [N-1:0]   winner;
  logic           any_req;

  // Winner select: the low half holds only requesters above the pointer, the
  // high half holds all of them (wrap-around). Isolating the lowest set bit
  // of the doubled vector and folding the halves gives a one-hot winner.
  always_comb begin
    above_last = ~((last_oh_q - ONE_N) | last_oh_q);
    masked_req = request & above_last;
    dbl_req    = {request, masked_req};
    dbl_iso    = dbl_req & (~dbl_req + ONE_2N);
    winner     = dbl_iso[N-1:0] | dbl_iso[2*N-1:N];
    any_req    = |request;
  end

  // Next-state logic: load a new winner from IDLE or on a HOLD transfer,
  // drop back to IDLE when a transfer happens with nothing pending.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_oh_d = last_oh_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d   = winner;
          last_oh_d = winner;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (grant_ready) begin
          if (any_req) begin
            grant_d   = winner;
            last_oh_d = winner;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset clears the offer immediately and parks the
  // pointer on the top requester so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_oh_q <= LAST_INIT;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_oh_q <= last_oh_d;
    end
  end

  assign grant_valid = (state_q == HOLD);
  assign grant_oh    = grant_q;
  assign dbg_state_o = (state_q == HOLD);

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (NUM_REQUESTS=4): directed scenarios followed by
// random request/ready traffic, checked against a round-robin model that
// tracks the last granted index as an integer.
module tb_rr_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] request;
  logic         grant_valid;
  logic         grant_ready;
  logic [N-1:0] grant_oh;
  logic         dbg_state_o;

  int n_checks = 0;
  int n_fails  = 0;

  // Scoreboard entries: {expected valid, expected grant_oh}
  logic [N:0] exp_q[$];

  // Reference model state
  bit m_valid;
  int m_idx;
  int m_last;

  rr_arbiter #(.NUM_REQUESTS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .grant_oh    (grant_oh),
    .dbg_state_o (dbg_state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] req);
    int w;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
    end
    return w;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_last  = N - 1;
  endtask

  task automatic push_expected();
    logic [N-1:0] oh;
    oh = '0;
    if (m_valid) oh[m_idx] = 1'b1;
    exp_q.push_back({m_valid, oh});
  endtask

  // One clock edge of the model
  task automatic model_edge(input logic [N-1:0] req, input logic rdy);
    if (!m_valid) begin
      if (req != '0) begin
        m_idx = pick(req); m_last = m_idx; m_valid = 1'b1;
      end
    end else if (rdy) begin
      if (req != '0) begin
        m_idx = pick(req); m_last = m_idx;
      end else begin
        m_valid = 1'b0;
      end
    end
    push_expected();
  endtask

  task automatic check(input string tag);
    logic [N:0] e;
    e = exp_q.pop_front();
    n_checks++;
    assert (grant_valid === e[N]) else begin
      n_fails++;
      $error("FAIL %s grant_valid observed %b expected %b", tag, grant_valid, e[N]);
    end
    n_checks++;
    assert (grant_oh === e[N-1:0]) else begin
      n_fails++;
      $error("FAIL %s grant_oh observed %b expected %b", tag, grant_oh, e[N-1:0]);
    end
    n_checks++;
    assert (dbg_state_o === e[N]) else begin
      n_fails++;
      $error("FAIL %s dbg_state observed %b expected %b", tag, dbg_state_o, e[N]);
    end
  endtask

  // Driver: apply inputs at the falling edge, check just after the rising edge
  task automatic step(input logic [N-1:0] req, input logic rdy, input string tag);
    @(negedge clk);
    request     = req;
    grant_ready = rdy;
    model_edge(req, rdy);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // Reset pulsed between edges; outputs must clear before the next edge
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    request     = '0;
    grant_ready = 1'b0;
    rst         = 1'b1;
    #1;
    model_reset();
    push_expected();
    check(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    request     = '0;
    grant_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    push_expected();
    check("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // First grant skips the idle requester 0
    step(4'b1010, 1'b0, "first_grant");
    step(4'b0000, 1'b0, "first_hold");
    step(4'b0000, 1'b1, "drain_idle");
    step(4'b0000, 1'b1, "ready_in_idle");

    // Full rotation with all requesting
    pulse_reset("reset_before_rotate");
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, "rotate");

    // Hold stable while request changes, then hand off
    pulse_reset("reset_before_hold");
    step(4'b1111, 1'b1, "hold_load0");
    step(4'b1111, 1'b1, "hold_load1");
    step(4'b1111, 1'b1, "hold_load2");
    for (int i = 0; i < 5; i++) step(4'b0001, 1'b0, "hold_stable");
    step(4'b0001, 1'b1, "hold_handoff");

    // Sole requester 3 wins twice in a row
    step(4'b1000, 1'b1, "sole_first");
    step(4'b1000, 1'b1, "sole_wrap");
    step(4'b0000, 1'b1, "return_idle");
    step(4'b0000, 1'b0, "stay_idle");

    // Reset in the middle of a held grant
    step(4'b0010, 1'b0, "pre_reset_grant");
    step(4'b0000, 1'b0, "pre_reset_hold");
    pulse_reset("reset_mid_hold");
    step(4'b0011, 1'b0, "post_reset_grant");

    // Random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset("rand_reset");
      else step(N'($urandom_range(0, (1 << N) - 1)), 1'($urandom_range(0, 1)), "random");
    end

    // Fairness: continuous full requests rotate through every index
    for (int i = 0; i < 2 * N; i++) step(4'b1111, 1'b1, "fair");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter NUM_REQUESTS, default 4, number of requesters; SHALL be legal for any value >= 1.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port request  input  NUM_REQUESTS  per-requester request level, bit i = requester i.
REQ-005 Port grant_valid  output  1  grant_oh holds a valid grant.
REQ-006 Port grant_ready  input  1  consumer accepts the current grant; handshake = grant_valid & grant_ready.
REQ-007 Port grant_oh  output  NUM_REQUESTS  one-hot grant vector, bit i = requester i, index 0 = LSB; drives a one-hot-to-index encoder downstream.

Function
REQ-008 grant_valid and grant_oh SHALL be registered outputs; no combinational path from request or grant_ready to any output.
REQ-009 grant_oh SHALL be all-zero whenever grant_valid=0, and exactly one bit set whenever grant_valid=1.
REQ-010 State machine, two states: IDLE (grant_valid=0) and HOLD (grant_valid=1).
REQ-011 IDLE: if request != 0 at a clock edge -> load winner into grant_oh, go to HOLD; else stay IDLE.
REQ-012 HOLD without handshake: grant_oh and grant_valid SHALL remain stable; request changes, including deassertion of the granted bit, SHALL be ignored.
REQ-013 HOLD with handshake and request != 0: load the next winner in the same edge and stay in HOLD (back-to-back grants, one per cycle).
REQ-014 HOLD with handshake and request == 0: clear grant_oh, go to IDLE.
REQ-015 Latency: request sampled at edge t -> grant_valid=1 after edge t; no bubble between consecutive grants while grant_ready=1.
REQ-016 Priority pointer: register last_oh (NUM_REQUESTS bits, one-hot) SHALL record the most recently loaded winner, updated only when a new winner is loaded.
REQ-017 Winner = first set bit of request, scanning upward from position (index of last_oh)+1 and wrapping from NUM_REQUESTS-1 to 0.
REQ-018 Wrap-around: the previously granted requester SHALL have lowest priority; if it is the only requester, it SHALL win again.
REQ-019 Fairness: with requests continuously asserted, any requesting bit SHALL be granted within NUM_REQUESTS successive grants.
REQ-020 Winner selection SHALL use a double-width masked priority scan or equivalent; the result SHALL be one-hot by construction.
REQ-021 NUM_REQUESTS=1: grant_oh=1 whenever grant_valid=1; pointer logic degenerates without width errors.
REQ-022 grant_ready while grant_valid=0 SHALL have no effect.

Reset
REQ-023 On rst assertion, grant_valid=0 and grant_oh=0 SHALL take effect immediately, without waiting for clk.
REQ-024 On reset, last_oh SHALL be bit NUM_REQUESTS-1, so requester 0 has top priority on the first grant.
REQ-025 Reset mid-HOLD SHALL discard the pending grant; no handshake is implied; state returns to IDLE.
REQ-026 First edge after rst deassertion SHALL behave as IDLE with reset pointer.

Verification (NUM_REQUESTS=4)
REQ-027 After reset, request=4'b1010 for one edge -> grant_valid=1, grant_oh=4'b0010 next cycle.
REQ-028 request=4'b1111 held, grant_ready=1 -> grant_oh sequence 0001,0010,0100,1000,0001 on consecutive cycles, grant_valid continuously 1.
REQ-029 Grant 0100 held with grant_ready=0 for 5 cycles while request changes to 4'b0001 -> grant_oh stays 0100; on handshake, next grant_oh=0001.
REQ-030 Last grant 1000, request=4'b1000 only, handshake -> grant_oh=1000 again (wrap, sole requester).
REQ-031 HOLD with grant_oh=0010, rst pulsed between edges -> grant_valid=0, grant_oh=0 before next edge; after release, request=4'b0011 -> grant_oh=0001.
REQ-032 Single grant, handshake with request=0 -> grant_valid=0, grant_oh=0 next cycle; state IDLE.
